sram_req_adapter: RTL
=====================

Name: sram_req_adapter

Overview:
- Front-end controller for the 64x20 single-port SRAM macro (active-low CEB/WEB, 1-cycle read latency, Q undefined on non-read cycles).
- Converts independent valid/ready write and read request channels into per-cycle macro commands.
- Zero-initialises the array after reset.
- Buffers read data in a 2-entry response queue so that a stalled consumer never loses data.

Parameters:
Bits, 20, data width; matches macro word width
Word_Depth, 64, number of macro entries
Add_Width, 6, address width, log2(Word_Depth)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
init_done  output  1  high once the zero-fill sweep completes
w_valid  input  1  write request valid
w_ready  output  1  write request accepted this cycle when w_valid also high
w_addr  input  Add_Width  write address
w_data  input  Bits  write data
r_valid  input  1  read request valid
r_ready  output  1  read request accepted this cycle when r_valid also high
r_addr  input  Add_Width  read address
resp_valid  output  1  read response valid
resp_ready  input  1  consumer accepts response
resp_data  output  Bits  read response data
sram_CEB  output  1  macro chip enable, active low
sram_WEB  output  1  macro write enable, active low (1 = read)
sram_A  output  Add_Width  macro address
sram_D  output  Bits  macro write data
sram_Q  input  Bits  macro read data, valid only in the cycle after a read command

Behaviour:
- Reset (async) values:
  - State = INIT, init counter = 0, init_done = 0.
  - Queue empty, inflight = 0, round-robin pointer = write-first.
  - w_ready = r_ready = resp_valid = 0.
- Macro command outputs are combinational from state and the accepted request:
  - Idle cycle: sram_CEB = 1, sram_WEB = 1, sram_A = 0, sram_D = 0.
- INIT state:
  - Each cycle drives a write: CEB = 0, WEB = 0, A = counter, D = 0. Counter then increments.
  - w_ready and r_ready held at 0.
  - After the write to Word_Depth-1 (Word_Depth cycles total), go to RUN and set init_done = 1 from the next cycle.
  - Counter width is Add_Width; the terminal condition is counter == Word_Depth-1, not counter overflow.
- RUN state, arbitration:
  - At most one macro command per cycle.
  - Write eligible: w_valid.
  - Read eligible: r_valid && credit_ok.
  - credit_ok = (count + inflight - pop) < 2, where pop = resp_valid && resp_ready.
  - Only one channel eligible: that channel wins.
  - Both eligible: round-robin. The pointer starts write-first and toggles after each contended grant.
  - w_ready / r_ready are asserted only for the granted channel. They may depend combinationally on w_valid/r_valid and resp_ready.
- Read pipeline:
  - Read granted in cycle t: CEB = 0, WEB = 1, A = r_addr. inflight = 1 in cycle t+1.
  - In cycle t+1, sram_Q holds the data.
    - Queue empty: resp_valid = 1, resp_data = sram_Q (bypass, 1-cycle latency). If resp_ready is low, sram_Q is pushed into the queue at the end of t+1.
    - Queue non-empty: sram_Q is pushed at the end of t+1. Head-of-queue is presented; order is strictly preserved.
  - Simultaneous push and pop in one cycle is legal and leaves count unchanged.
  - The credit rule guarantees the queue never overflows.
- Write: granted cycle drives CEB = 0, WEB = 0, A = w_addr, D = w_data. No response is generated.
- Read-after-write to the same address in a later cycle returns the new data. A read and a write can never issue in the same cycle.
- Reset asserted mid-operation:
  - Inflight read is discarded and the queue is flushed.
  - Returns to INIT and the full zero-fill repeats.
  - No resp_valid while reset is high.
- Full throughput: back-to-back reads at 1 per cycle with resp_ready held high.

Test Plan:
- Init sweep: release reset → exactly 64 cycles of CEB=0/WEB=0, A=0..63, D=0, then init_done=1. Every subsequent read of any address returns 0.
- Write/read: write 0xABCDE to addr 5, then read addr 5 the next cycle → resp_valid exactly 1 cycle after r_ready, resp_data=0xABCDE.
- Backpressure: issue 4 reads (addrs 1,2,3,4 preloaded with 0x11,0x22,0x33,0x44) with resp_ready=0.
  - Only 2 are accepted; r_ready stays low afterwards.
  - Raising resp_ready yields 0x11 then 0x22 in order, and the remaining reads are accepted.
- Contention: w_valid and r_valid held high for 4 cycles → grants alternate W,R,W,R. No cycle has both ready signals high.
- Streaming: 64 consecutive reads with resp_ready=1 → one response per cycle, no bubbles, data matches written pattern.
- Mid-op reset: assert reset with 1 inflight read and 1 queued response → resp_valid=0 immediately, INIT restarts, prior contents read back as 0.

Source files
------------

// File: rtl/sram_req_adapter_if.sv
// -----------------------------------------------------------------------------
// sram_req_adapter_if
//   Request/response bundle between a client and sram_req_adapter.
//
//   Write channel : w_valid, w_ready, w_addr, w_data
//   Read channel  : r_valid, r_ready, r_addr
//   Response      : resp_valid, resp_ready, resp_data
//
//   master modport : client side (issues requests, consumes responses)
//   slave modport  : adapter side
// -----------------------------------------------------------------------------
interface sram_req_adapter_if #(
    parameter int Bits      = 20,
    parameter int Add_Width = 6
);
    logic                 w_valid;
    logic                 w_ready;
    logic [Add_Width-1:0] w_addr;
    logic [Bits-1:0]      w_data;

    logic                 r_valid;
    logic                 r_ready;
    logic [Add_Width-1:0] r_addr;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [Bits-1:0]      resp_data;

    modport master (
        output w_valid, w_addr, w_data,
        input  w_ready,
        output r_valid, r_addr,
        input  r_ready,
        input  resp_valid, resp_data,
        output resp_ready
    );

    modport slave (
        input  w_valid, w_addr, w_data,
        output w_ready,
        input  r_valid, r_addr,
        output r_ready,
        output resp_valid, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/sram_req_adapter.sv
// -----------------------------------------------------------------------------
// sram_req_adapter
//   Front-end controller for a single-port SRAM macro (active-low CEB/WEB,
//   one-cycle read latency, Q only meaningful in the cycle after a read).
//   After reset it sweeps the whole array with zeros, then arbitrates between
//   a write and a read request channel, issuing at most one macro command per
//   cycle. Read data returns through a 2-entry response queue with a bypass
//   path, so a stalled consumer never loses data and an unstalled one sees
//   one-cycle latency at full throughput.
//
//   Ports:
//     clock, reset        rising-edge clock, asynchronous active-high reset
//     init_done           high once the zero-fill sweep has completed
//     bus (slave)         write / read request channels and read response
//     sram_CEB, sram_WEB  macro chip / write enable, active low
//     sram_A, sram_D      macro address and write data
//     sram_Q              macro read data
// -----------------------------------------------------------------------------
module sram_req_adapter #(
    parameter int Bits       = 20,
    parameter int Word_Depth = 64,
    parameter int Add_Width  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 init_done,
    sram_req_adapter_if.slave    bus,
    output logic                 sram_CEB,
    output logic                 sram_WEB,
    output logic [Add_Width-1:0] sram_A,
    output logic [Bits-1:0]      sram_D,
    input  logic [Bits-1:0]      sram_Q
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [Add_Width-1:0] LAST_ADDR = Add_Width'(Word_Depth - 1);

    state_t               state;
    logic [Add_Width-1:0] init_cnt;
    logic                 rr_read_first;  // 0: write wins the next contended cycle
    logic                 inflight;       // a read was issued last cycle

    logic [Bits-1:0]      q_mem [2];
    logic                 q_head;
    logic [1:0]           q_count;
    logic                 q_tail;

    logic                 resp_valid_int;
    logic                 pop;            // consumer takes the presented response
    logic                 q_push;         // sram_Q must be captured this cycle
    logic                 q_pop;          // queue head leaves this cycle
    logic [2:0]           occupancy;
    logic                 credit_ok;
    logic                 w_elig;
    logic                 r_elig;
    logic                 grant_w;
    logic                 grant_r;

    // -------------------------------------------------------------------------
    // Response path
    // -------------------------------------------------------------------------
    assign q_tail         = q_head ^ q_count[0];
    assign resp_valid_int = inflight || (q_count != 2'd0);
    assign pop            = resp_valid_int && bus.resp_ready;

    // With an empty queue the macro output is presented directly; it only
    // needs capturing if the consumer does not take it this cycle.
    assign q_push = inflight && !((q_count == 2'd0) && bus.resp_ready);
    assign q_pop  = (q_count != 2'd0) && bus.resp_ready;

    assign bus.resp_valid = resp_valid_int;
    assign bus.resp_data  = (q_count == 2'd0) ? sram_Q : q_mem[q_head];

    // Responses already owed (queued + in flight) minus the one leaving now
    // must leave room for one more read, so the queue can never overflow.
    assign occupancy = {1'b0, q_count} + {2'b00, inflight} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        w_elig  = 1'b0;
        r_elig  = 1'b0;
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state == ST_RUN) begin
            w_elig  = bus.w_valid;
            r_elig  = bus.r_valid && credit_ok;
            grant_w = w_elig && (!r_elig || !rr_read_first);
            grant_r = r_elig && (!w_elig || rr_read_first);
        end
    end

    assign bus.w_ready = grant_w;
    assign bus.r_ready = grant_r;

    // -------------------------------------------------------------------------
    // Macro command
    // -------------------------------------------------------------------------
    always_comb begin
        sram_CEB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_D   = '0;
        // Nothing is driven to the macro while reset is held.
        if (!reset) begin
            if (state == ST_INIT) begin
                sram_CEB = 1'b0;
                sram_WEB = 1'b0;
                sram_A   = init_cnt;
            end else if (grant_w) begin
                sram_CEB = 1'b0;
                sram_WEB = 1'b0;
                sram_A   = bus.w_addr;
                sram_D   = bus.w_data;
            end else if (grant_r) begin
                sram_CEB = 1'b0;
                sram_A   = bus.r_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            init_cnt      <= '0;
            init_done     <= 1'b0;
            rr_read_first <= 1'b0;
            inflight      <= 1'b0;
            q_head        <= 1'b0;
            q_count       <= 2'd0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    // Terminal count is the last word, not counter wrap, so
                    // non-power-of-two depths sweep correctly.
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_elig && r_elig) begin
                        rr_read_first <= !rr_read_first;
                    end
                end
                default: state <= ST_INIT;
            endcase

            inflight <= grant_r;

            if (q_pop) begin
                q_head <= !q_head;
            end
            case ({q_push, q_pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; validity is tracked by q_count, so
    // the data flops need no reset and stay plain registers.
    always_ff @(posedge clock) begin
        if (q_push) begin
            q_mem[q_tail] <= sram_Q;
        end
    end

endmodule
